// File: rtl/vector_cmd_fifo_if.sv
// Host/engine handshake bundle for vector_cmd_fifo.
// master = host + engine side (drives strobes), slave = the FIFO itself.
interface vector_cmd_fifo_if #(
    parameter int ADDR_W = 9
);
    logic [7:0]      wr_data;
    logic            wr_en;
    logic            commit;
    logic            abort;
    logic            rd_en;
    logic [7:0]      rd_data;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] level;
    logic            overflow;
    logic            packet_dropped;

    modport master (
        output wr_data, wr_en, commit, abort, rd_en,
        input  rd_data, empty, full, level, overflow, packet_dropped
    );

    modport slave (
        input  wr_data, wr_en, commit, abort, rd_en,
        output rd_data, empty, full, level, overflow, packet_dropped
    );
endinterface

// File: rtl/vector_cmd_fifo.sv
// Byte FIFO with packet commit/abort: staged host bytes become visible to the
// engine only once committed, so the engine never sees a partial command.
module vector_cmd_fifo #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    vector_cmd_fifo_if.slave   bus
);
    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);

    logic [7:0] mem [DEPTH];

    logic [PTR_W-1:0] rp_q, rp_d;
    logic [PTR_W-1:0] wp_commit_q, wp_commit_d;
    logic [PTR_W-1:0] wp_stage_q, wp_stage_d;
    logic [PTR_W-1:0] wp_stage_inc;
    logic [PTR_W-1:0] level_q, level_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic             packet_dropped_q, packet_dropped_d;
    logic [7:0]       rd_data_q;
    logic             wr_accept;
    logic             rd_accept;

    // Abort outranks commit; a commit on an overflowed packet degrades to an abort.
    always_comb begin
        wr_accept        = bus.wr_en && !full_q;
        rd_accept        = bus.rd_en && !empty_q;
        wp_stage_inc     = wp_stage_q + {{ADDR_W{1'b0}}, wr_accept};
        rp_d             = rp_q + {{ADDR_W{1'b0}}, rd_accept};
        wp_commit_d      = wp_commit_q;
        wp_stage_d       = wp_stage_inc;
        overflow_d       = overflow_q;
        packet_dropped_d = 1'b0;

        if (bus.abort) begin
            wp_stage_d = wp_commit_q;
            overflow_d = 1'b0;
        end else if (bus.commit && overflow_q) begin
            wp_stage_d       = wp_commit_q;
            overflow_d       = 1'b0;
            packet_dropped_d = 1'b1;
        end else begin
            if (bus.wr_en && full_q) begin
                overflow_d = 1'b1;
            end
            if (bus.commit) begin
                wp_commit_d = wp_stage_inc;
            end
        end

        // Flags come from next-state pointers so the registered copies are exact.
        empty_d = (rp_d == wp_commit_d);
        full_d  = ((wp_stage_d - rp_d) == DEPTH_PTR);
        level_d = wp_commit_d - rp_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rp_q             <= '0;
            wp_commit_q      <= '0;
            wp_stage_q       <= '0;
            level_q          <= '0;
            empty_q          <= 1'b1;
            full_q           <= 1'b0;
            overflow_q       <= 1'b0;
            packet_dropped_q <= 1'b0;
        end else begin
            rp_q             <= rp_d;
            wp_commit_q      <= wp_commit_d;
            wp_stage_q       <= wp_stage_d;
            level_q          <= level_d;
            empty_q          <= empty_d;
            full_q           <= full_d;
            overflow_q       <= overflow_d;
            packet_dropped_q <= packet_dropped_d;
        end
    end

    // Storage has no reset so it maps onto block RAM; stale bytes are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wp_stage_q[ADDR_W-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_accept) begin
            rd_data_q <= mem[rp_q[ADDR_W-1:0]];
        end
    end

    assign bus.rd_data        = rd_data_q;
    assign bus.empty          = empty_q;
    assign bus.full           = full_q;
    assign bus.level          = level_q;
    assign bus.overflow       = overflow_q;
    assign bus.packet_dropped = packet_dropped_q;
endmodule

// File: tb/tb_vector_cmd_fifo.sv
// Scoreboard bench for vector_cmd_fifo: committed bytes are queued as expected
// read data and a separate monitor pops and compares each delivered byte.
module tb_vector_cmd_fifo;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    logic [7:0] exp_q[$];
    logic [7:0] staged_q[$];
    logic       ovf_m;
    logic       drop_m;

    vector_cmd_fifo_if #(.ADDR_W(ADDR_W)) f ();

    vector_cmd_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a read accepted at an edge must deliver the oldest committed byte right after it.
    initial begin
        logic       acc;
        logic [7:0] want;
        forever begin
            @(posedge clk);
            acc = f.rd_en && !f.empty && !reset;
            #2;
            if (acc) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL rd_data_unexpected: got %02h, no committed byte outstanding", f.rd_data);
                end else begin
                    want = exp_q.pop_front();
                    checkOutput("rd_data", 32'(f.rd_data), 32'(want));
                end
            end
        end
    end

    task automatic checkFlags();
        checkOutput("empty", 32'(f.empty), 32'(exp_q.size() == 0));
        checkOutput("level", 32'(f.level), 32'(exp_q.size()));
        checkOutput("full", 32'(f.full), 32'((staged_q.size() + exp_q.size()) == DEPTH));
        checkOutput("overflow", 32'(f.overflow), 32'(ovf_m));
        checkOutput("packet_dropped", 32'(f.packet_dropped), 32'(drop_m));
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic cm,
                                 input logic ab, input logic re);
        logic full_m;
        f.wr_en   = we;
        f.wr_data = wd;
        f.commit  = cm;
        f.abort   = ab;
        f.rd_en   = re;
        full_m = (staged_q.size() + exp_q.size()) == DEPTH;
        drop_m = 1'b0;
        if (ab) begin
            staged_q.delete();
            ovf_m = 1'b0;
        end else if (cm && ovf_m) begin
            staged_q.delete();
            ovf_m  = 1'b0;
            drop_m = 1'b1;
        end else begin
            if (we && !full_m) staged_q.push_back(wd);
            if (we && full_m) ovf_m = 1'b1;
            if (cm) begin
                foreach (staged_q[i]) exp_q.push_back(staged_q[i]);
                staged_q.delete();
            end
        end
        @(posedge clk);
        #3;
        checkFlags();
    endtask

    task automatic applyReset(input logic re);
        reset     = 1'b1;
        f.wr_en   = 1'b0;
        f.wr_data = 8'h00;
        f.commit  = 1'b0;
        f.abort   = 1'b0;
        f.rd_en   = re;
        @(posedge clk);
        #3;
        exp_q.delete();
        staged_q.delete();
        ovf_m  = 1'b0;
        drop_m = 1'b0;
        checkOutput("rst_rd_data", 32'(f.rd_data), 32'h0);
        checkOutput("rst_empty", 32'(f.empty), 32'h1);
        checkOutput("rst_full", 32'(f.full), 32'h0);
        checkOutput("rst_level", 32'(f.level), 32'h0);
        checkOutput("rst_overflow", 32'(f.overflow), 32'h0);
        checkOutput("rst_packet_dropped", 32'(f.packet_dropped), 32'h0);
        reset = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 2 * DEPTH + 8) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            n++;
        end
        checkOutput("drain_done", 32'(exp_q.size()), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] pkt2 [5];
        logic [7:0] b;
        int         k;
        n_checks = 0;
        n_fails  = 0;
        ovf_m    = 1'b0;
        drop_m   = 1'b0;
        reset    = 1'b1;
        f.wr_en = 1'b0; f.wr_data = 8'h00; f.commit = 1'b0; f.abort = 1'b0; f.rd_en = 1'b0;
        #2;
        applyReset(1'b0);

        $display("[TB] staged bytes stay hidden until commit");
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_rd_data_hidden0", 32'(f.rd_data), 32'h0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_rd_data_hidden1", 32'(f.rd_data), 32'h0);
        checkOutput("t1_empty_before", 32'(f.empty), 32'h1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("t1_empty_after", 32'(f.empty), 32'h0);
        checkOutput("t1_level", 32'(f.level), 32'h2);
        drain();

        $display("[TB] commit with same-cycle write, reads held high");
        pkt2 = '{8'h13, 8'h00, 8'h0A, 8'h00, 8'h14};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, pkt2[i], (i == 4), 1'b0, 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("t2_last_byte", 32'(f.rd_data), 32'h14);
        checkOutput("t2_empty_end", 32'(f.empty), 32'h1);

        $display("[TB] abort rolls back only staged bytes");
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hE3, 1'b1, 1'b1, 1'b0);
        checkOutput("t3_level_kept", 32'(f.level), 32'h2);
        checkOutput("t3_no_drop", 32'(f.packet_dropped), 32'h0);
        applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB2, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_level_new", 32'(f.level), 32'h4);
        drain();

        $display("[TB] overflow of a single packet");
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == DEPTH - 1) checkOutput("t4_full_at_depth", 32'(f.full), 32'h1);
        end
        checkOutput("t4_overflow", 32'(f.overflow), 32'h1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_packet_dropped", 32'(f.packet_dropped), 32'h1);
        checkOutput("t4_empty", 32'(f.empty), 32'h1);
        checkOutput("t4_overflow_clr", 32'(f.overflow), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_drop_pulse_end", 32'(f.packet_dropped), 32'h0);

        $display("[TB] streaming packets of 5 with concurrent reads");
        k = 0;
        while (k < 3 * DEPTH) begin
            for (int j = 0; j < 5; j++) begin
                b = 8'(k * 7 + 3);
                applyStimulus(1'b1, b, (j == 4), 1'b0, 1'b1);
                k++;
            end
        end
        drain();

        $display("[TB] reset mid-packet and mid-read");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'h40 + 8'(i), (i == 3), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h5B, 1'b0, 1'b0, 1'b1);
        applyReset(1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_no_stale", 32'(f.empty), 32'h1);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h78, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_level", 32'(f.level), 32'h2);
        drain();
        checkOutput("t6_final_byte", 32'(f.rd_data), 32'h78);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
